shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 108 ++++++++++
 tb/tb_shift_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: decodes a shift instruction, then shifts one bit per
// clock until the loaded count expires, publishing the value with a done pulse.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [3:0]       ffield,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic [1:0]       sh_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       dec_op;

    always_comb begin
        dec_op = OP_PASS;
        if (opcode == 4'b0000) begin
            case (ffield)
                4'b1000: dec_op = OP_SLL;
                4'b1001: dec_op = OP_SRL;
                4'b1010: dec_op = OP_SRA;
                default: dec_op = OP_PASS;
            endcase
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = data_in;
                    op_d    = dec_op;
                    cnt_d   = (dec_op == OP_PASS) ? '0 : amount;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                    // Bits leaving the register are dropped; no rotation.
                    case (op_q)
                        OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
                        OP_SRL:  work_d = {1'b0, work_q[WIDTH-1:1]};
                        OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                        default: work_d = work_q;
                    endcase
                end else begin
                    result_d = work_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_PASS;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign sh_op  = (state_q == ST_IDLE) ? OP_PASS : op_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: each accepted operation pushes its
// expected result and busy length, popped and compared when done is seen.
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       opcode;
    logic [3:0]       ffield;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       sh_op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               busy_cyc;
        logic [1:0]       op;
    } exp_t;

    exp_t sb[$];

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .opcode  (opcode),
        .ffield  (ffield),
        .amount  (amount),
        .data_in (data_in),
        .sh_op   (sh_op),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] model_decode(logic [3:0] opc, logic [3:0] fld);
        if (opc != 4'b0000) return 2'b00;
        case (fld)
            4'b1000: return 2'b01;
            4'b1001: return 2'b10;
            4'b1010: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] model_shift(logic [1:0] op, logic [WIDTH-1:0] d, int n);
        logic signed [WIDTH-1:0] s;
        s = d;
        case (op)
            2'b01:   return d << n;
            2'b10:   return d >> n;
            2'b11:   return s >>> n;
            default: return d;
        endcase
    endfunction

    // One operation: use_ref selects a hand-computed result instead of the model.
    task automatic run_op(input logic [3:0] opc, input logic [3:0] fld,
                          input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] din,
                          input bit poke, input bit use_ref,
                          input logic [WIDTH-1:0] ref_res, input string tag);
        exp_t e;
        exp_t got;
        int   n;
        int   busy_cnt;
        bit   seen;
        e.op       = model_decode(opc, fld);
        n          = (e.op == 2'b00) ? 0 : int'(amt);
        e.res      = use_ref ? ref_res : model_shift(e.op, din, n);
        e.busy_cyc = n + 1;
        sb.push_back(e);

        @(negedge clk);
        opcode = opc; ffield = fld; amount = amt; data_in = din; start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        opcode  = 4'($urandom);
        ffield  = 4'($urandom);
        amount  = AMT_W'($urandom);
        data_in = WIDTH'($urandom);

        busy_cnt = 0;
        seen     = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            n_checks++;
            if (busy !== 1'b1 || sh_op !== e.op) begin
                n_errors++;
                $display("FAIL %s busy/sh_op: got busy=%b sh_op=%b, want busy=1 sh_op=%b",
                         tag, busy, sh_op, e.op);
            end
            busy_cnt++;
            if (poke) begin
                start   = 1'b1;
                opcode  = 4'b0000;
                ffield  = 4'b1001;
                amount  = AMT_W'($urandom);
                data_in = WIDTH'($urandom);
            end
        end

        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s timeout: no done within 100 cycles", tag);
            if (sb.size() > 0) void'(sb.pop_front());
            start = 1'b0;
            return;
        end

        got = sb.pop_front();
        n_checks++;
        if (result !== got.res) begin
            n_errors++;
            $display("FAIL %s result: got %h, want %h", tag, result, got.res);
        end
        n_checks++;
        if (busy_cnt != got.busy_cyc) begin
            n_errors++;
            $display("FAIL %s busy_cycles: got %0d, want %0d", tag, busy_cnt, got.busy_cyc);
        end
        n_checks++;
        if (busy !== 1'b0 || sh_op !== got.op) begin
            n_errors++;
            $display("FAIL %s done_state: got busy=%b sh_op=%b, want busy=0 sh_op=%b",
                     tag, busy, sh_op, got.op);
        end

        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sh_op !== 2'b00 || result !== got.res) begin
            n_errors++;
            $display("FAIL %s after_done: got done=%b busy=%b sh_op=%b result=%h, want 0 0 00 %h",
                     tag, done, busy, sh_op, result, got.res);
        end
        if (poke) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL %s start_lost: got done=%b busy=%b, want 0 0", tag, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; opcode = '0; ffield = '0; amount = '0; data_in = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sh_op !== 2'b00 || result !== '0) begin
            n_errors++;
            $display("FAIL reset_async: got busy=%b done=%b sh_op=%b result=%h, want 0 0 00 0000",
                     busy, done, sh_op, result);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_errors++;
            $display("FAIL reset_release: got busy=%b done=%b result=%h, want 0 0 0000",
                     busy, done, result);
        end
    endtask

    task automatic test_sll();
        run_op(4'b0000, 4'b1000, 4'd1, 16'h8001, 1'b0, 1'b1, 16'h0002, "sll_1");
    endtask

    task automatic test_sra_srl();
        run_op(4'b0000, 4'b1010, 4'd4, 16'h8000, 1'b0, 1'b1, 16'hF800, "sra_4");
        run_op(4'b0000, 4'b1001, 4'd4, 16'h8000, 1'b0, 1'b1, 16'h0800, "srl_4");
    endtask

    task automatic test_max_amount();
        run_op(4'b0000, 4'b1000, 4'd15, 16'h0001, 1'b0, 1'b1, 16'h8000, "sll_max");
        run_op(4'b0000, 4'b1001, 4'd15, 16'hFFFF, 1'b0, 1'b1, 16'h0001, "srl_max");
    endtask

    task automatic test_pass();
        run_op(4'b0001, 4'b1000, 4'd7, 16'h1234, 1'b0, 1'b1, 16'h1234, "pass_opc");
        run_op(4'b0000, 4'b1011, 4'd9, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF, "pass_fld");
        run_op(4'b0000, 4'b1000, 4'd0, 16'hA5A5, 1'b0, 1'b1, 16'hA5A5, "sll_zero");
    endtask

    task automatic test_start_while_busy();
        run_op(4'b0000, 4'b1010, 4'd3, 16'h9000, 1'b1, 1'b1, 16'hF200, "busy_start");
    endtask

    task automatic test_reset_mid_shift();
        bit pulsed;
        @(negedge clk);
        opcode = 4'b0000; ffield = 4'b1000; amount = 4'd8; data_in = 16'h00FF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset_pre: got busy=%b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sh_op !== 2'b00 || result !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_async: got busy=%b done=%b sh_op=%b result=%h, want 0 0 00 0000",
                     busy, done, sh_op, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulsed = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) pulsed = 1'b1;
        end
        n_checks++;
        if (pulsed || result !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_abort: got activity=%b result=%h, want 0 0000", pulsed, result);
        end
        run_op(4'b0000, 4'b1000, 4'd4, 16'h0F0F, 1'b0, 1'b1, 16'hF0F0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [3:0] flds [4];
        flds[0] = 4'b1000; flds[1] = 4'b1001; flds[2] = 4'b1010; flds[3] = 4'b0110;
        for (int i = 0; i < 12; i++) begin
            run_op((i % 5 == 4) ? 4'b0011 : 4'b0000, flds[$urandom_range(0, 3)],
                   AMT_W'($urandom), WIDTH'($urandom), 1'b0, 1'b0, '0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_max_amount();
        test_pass();
        test_start_while_busy();
        test_reset_mid_shift();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got %0d entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
